sysid_regs: RTL

- Parametrised system-identification register block; successor to the fixed two-word sysid slave.
- Avalon-MM slave with a configurable pipelined read latency and an 8-word map:
  - ID, timestamp, version and feature constants
  - a writable scratch word
  - a 64-bit free-running uptime counter with atomic high-word snapshot
  - control/status bits
- Host software uses it to check hardware/software compatibility and measure uptime.

---
 rtl/sysid_pkg.sv | 25 ++
 rtl/sysid_rd_pipe.sv | 38 +++
 rtl/sysid_regs.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sysid_pkg.sv
// sysid_pkg: shared address map and control bit layout
// for the system-identification register block.
package sysid_pkg;

    localparam logic [2:0] ADDR_SYSID   = 3'd0;
    localparam logic [2:0] ADDR_TSTAMP  = 3'd1;
    localparam logic [2:0] ADDR_VERSION = 3'd2;
    localparam logic [2:0] ADDR_FEATURE = 3'd3;
    localparam logic [2:0] ADDR_SCRATCH = 3'd4;
    localparam logic [2:0] ADDR_UP_LO   = 3'd5;
    localparam logic [2:0] ADDR_UP_HI   = 3'd6;
    localparam logic [2:0] ADDR_CTRL    = 3'd7;

    localparam int CTRL_CLR    = 0;
    localparam int CTRL_FREEZE = 1;
    localparam int CTRL_ERR    = 8;

    // One bit per word; set where a write is illegal.
    localparam logic [7:0] RO_MASK = 8'b0110_1111;

    function automatic logic is_ro(input logic [2:0] a);
        return RO_MASK[a];
    endfunction

endpackage

// File: rtl/sysid_rd_pipe.sv
// sysid_rd_pipe: valid/data delay line for read responses.
// Data stages only load when valid moves in, so the output holds.
module sysid_rd_pipe #(
    parameter int DEPTH = 1,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [DEPTH-1:0]        vld;
    logic [DEPTH-1:0][W-1:0] dat;

    // Shift valid every cycle; advance data only behind a valid.
    always_ff @(posedge clk) begin
        if (clr) begin
            vld <= '0;
            dat <= '0;
        end else begin
            vld[0] <= in_valid;
            if (in_valid)
                dat[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1])
                    dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/sysid_regs.sv
// sysid_regs: ID/version constants, scratch word, 64-bit
// uptime with atomic high-word snapshot, and control/status.
module sysid_regs
    import sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID     = 32'h4E139039,
    parameter logic [31:0] TIMESTAMP     = 32'h2E95A7A8,
    parameter logic [31:0] VERSION       = 32'h0001_0200,
    parameter logic [31:0] FEATURES      = 32'h0000_0000,
    parameter int          READ_LATENCY  = 1,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        waitrequest
);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
            $fatal(1, "sysid_regs: READ_LATENCY must be 1..4");
        end
    endgenerate

    logic [31:0] scratch;
    logic [63:0] uptime;
    logic [31:0] hi_snap;
    logic        freeze;
    logic        err;

    logic        wr_scr;
    logic        wr_ctl;
    logic        err_set;
    logic        err_clr;
    logic        clr;
    logic        snap;
    logic [31:0] rd_mux;

    assign wr_scr  = write && (address == ADDR_SCRATCH);
    assign wr_ctl  = write && (address == ADDR_CTRL);
    assign err_set = write && is_ro(address);
    assign err_clr = wr_ctl && byteenable[1]
                     && writedata[CTRL_ERR];
    assign clr     = wr_ctl && byteenable[0]
                     && writedata[CTRL_CLR];
    assign snap    = read && (address == ADDR_UP_LO);

    // Read value from pre-write register state.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_SYSID:   rd_mux = SYSTEM_ID;
            ADDR_TSTAMP:  rd_mux = TIMESTAMP;
            ADDR_VERSION: rd_mux = VERSION;
            ADDR_FEATURE: rd_mux = FEATURES;
            ADDR_SCRATCH: rd_mux = scratch;
            ADDR_UP_LO:   rd_mux = uptime[31:0];
            ADDR_UP_HI:   rd_mux = hi_snap;
            default: begin
                rd_mux[CTRL_FREEZE] = freeze;
                rd_mux[CTRL_ERR]    = err;
            end
        endcase
    end

    // Scratch word, written per byte lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            scratch <= SCRATCH_RESET;
        end else if (wr_scr) begin
            for (int i = 0; i < 4; i++)
                if (byteenable[i])
                    scratch[8*i +: 8] <= writedata[8*i +: 8];
        end
    end

    // Free-running uptime; clear beats increment.
    always_ff @(posedge clk) begin
        if (reset)
            uptime <= '0;
        else if (clr)
            uptime <= '0;
        else if (!freeze)
            uptime <= uptime + 64'd1;
    end

    // Latch the high word whenever the low word is read.
    always_ff @(posedge clk) begin
        if (reset)
            hi_snap <= '0;
        else if (snap)
            hi_snap <= uptime[63:32];
    end

    // Freeze control and sticky error; set wins over clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            freeze <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (wr_ctl && byteenable[0])
                freeze <= writedata[CTRL_FREEZE];
            if (err_set)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end

    sysid_rd_pipe #(
        .DEPTH (READ_LATENCY),
        .W     (32)
    ) u_pipe (
        .clk       (clk),
        .clr       (reset),
        .in_valid  (read),
        .in_data   (rd_mux),
        .out_valid (readdatavalid),
        .out_data  (readdata)
    );

    assign waitrequest = 1'b0;

endmodule
